// File: rtl/partial_product_stage.sv
// ---------------------------------------------------------------------------
// partial_product_stage
//   Front end of the multiplier datapath. Accepts one (op_a, op_b) pair per
//   valid/ready handshake, forms the N = 2**EXPONENT shifted and gated partial
//   products, and registers them onto pp_bus for the combinational adder tree.
//   The bus is held for SETTLE_CYCLES cycles so the tree can settle. After
//   that, pp_valid is raised and held until the downstream stage accepts it.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   in_valid  operand pair valid
//   in_ready  stage can accept a pair (from state and pp_ready only)
//   op_a      multiplicand, DATA_WIDTH bits
//   op_b      multiplier, N bits
//   pp_bus    packed partial products, pp[0] in the LSBs
//   pp_valid  pp_bus settled and valid
//   pp_ready  downstream accepts pp_bus
//   busy      stage is not idle
// ---------------------------------------------------------------------------

// One partial product: op_a gated by a single multiplier bit, shifted into
// place and truncated to DATA_WIDTH bits.
module pp_lane #(
    parameter int DATA_WIDTH = 8,
    parameter int SHIFT      = 0
) (
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic                  bit_b,
    output logic [DATA_WIDTH-1:0] pp
);
    assign pp = (op_a & {DATA_WIDTH{bit_b}}) << SHIFT;
endmodule

module partial_product_stage #(
    parameter int EXPONENT      = 2,
    parameter int DATA_WIDTH    = 8,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH-1:0]            op_a,
    input  logic [(2**EXPONENT)-1:0]         op_b,
    output logic [(2**EXPONENT)*DATA_WIDTH-1:0] pp_bus,
    output logic                             pp_valid,
    input  logic                             pp_ready,
    output logic                             busy
);
    localparam int N     = 2**EXPONENT;
    localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;

    typedef enum logic [1:0] {IDLE, SETTLE, VALID} state_t;

    state_t                      state, state_next;
    logic [CNT_W-1:0]            cnt, cnt_next;
    logic                        load;
    logic [N*DATA_WIDTH-1:0]     pp_next;

    // Partial-product lanes, pp[i] = (op_a & op_b[i]) << i.
    for (genvar i = 0; i < N; i++) begin : g_lane
        pp_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .SHIFT      (i)
        ) u_lane (
            .op_a  (op_a),
            .bit_b (op_b[i]),
            .pp    (pp_next[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // in_ready deliberately ignores in_valid so there is no combinational
    // loop through an upstream that waits for ready before raising valid.
    assign in_ready = ~rst & ((state == IDLE) | ((state == VALID) & pp_ready));
    assign busy     = (state != IDLE);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) load = 1'b1;
            end
            SETTLE: begin
                if (cnt == '0) state_next = VALID;
                else           cnt_next   = cnt - 1'b1;
            end
            VALID: begin
                // Hand-off and reload can happen on the same edge.
                if (pp_ready) begin
                    if (in_valid) load       = 1'b1;
                    else          state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (load) begin
            if (SETTLE_CYCLES == 0) begin
                state_next = VALID;
            end else begin
                state_next = SETTLE;
                cnt_next   = CNT_LOAD;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            pp_bus   <= '0;
            pp_valid <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            pp_valid <= (state_next == VALID);
            if (load) pp_bus <= pp_next;
        end
    end
endmodule
